// File: rtl/index_walker_down.sv
// Descending (row, col) index generator for reverse-order matrix sweeps.
// Supports full-rectangle and upper-triangular (col >= row) traversal over a valid/ready stream.
module index_walker_down #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             upper,
    input  logic [WIDTH-1:0] last_row,
    input  logic [WIDTH-1:0] last_col,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] row,
    output logic [WIDTH-1:0] col,
    output logic             row_end,
    output logic             sweep_end,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | no sweep active; waits for start (abort has priority)
    // RUN   | emitting pairs; advances on each handshake
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] row_q, row_d;
    logic [WIDTH-1:0] col_q, col_d;
    logic [WIDTH-1:0] last_col_q, last_col_d;
    logic             upper_q, upper_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] col_min;
    logic             handshake;

    assign out_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign row       = row_q;
    assign col       = col_q;
    assign col_min   = upper_q ? row_q : '0;
    assign row_end   = out_valid && (col_q == col_min);
    assign sweep_end = row_end && (row_q == '0);
    assign handshake = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        last_col_d = last_col_q;
        upper_d    = upper_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d    = RUN;
                    upper_d    = upper;
                    last_col_d = last_col;
                    col_d      = last_col;
                    // Upper sweeps clamp the row bound so the first row is never empty.
                    row_d      = (upper && (last_row > last_col)) ? last_col : last_row;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (handshake) begin
                    if (sweep_end) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (row_end) begin
                        row_d = row_q - 1'b1;
                        col_d = last_col_q;
                    end else begin
                        col_d = col_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            last_col_q <= '0;
            upper_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            last_col_q <= last_col_d;
            upper_q    <= upper_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_index_walker_down.sv
// Self-checking bench for index_walker_down: expected pair sequences come from
// nested descending loops over the latched bounds, consumed under varied backpressure.
module tb_index_walker_down;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       upper;
    logic [7:0] last_row;
    logic [7:0] last_col;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] row;
    logic [7:0] col;
    logic       row_end;
    logic       sweep_end;
    logic       busy;
    logic       done;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [7:0] r;
        logic [7:0] c;
        logic       re;
        logic       se;
    } pair_t;

    pair_t exp_q[$];

    index_walker_down #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .upper(upper),
        .last_row(last_row), .last_col(last_col), .out_valid(out_valid),
        .out_ready(out_ready), .row(row), .col(col), .row_end(row_end),
        .sweep_end(sweep_end), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Build the expected pair list straight from the traversal rules.
    task automatic build_model(input int lr, input int lc, input bit up);
        int rb;
        pair_t p;
        exp_q.delete();
        rb = (up && lc < lr) ? lc : lr;
        for (int r = rb; r >= 0; r--) begin
            for (int c = lc; c >= (up ? r : 0); c--) begin
                p.r  = 8'(r);
                p.c  = 8'(c);
                p.re = (c == (up ? r : 0));
                p.se = p.re && (r == 0);
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic do_start(input int lr, input int lc, input bit up);
        @(negedge clk);
        start    = 1'b1;
        last_row = 8'(lr);
        last_col = 8'(lc);
        upper    = up;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Consume a full sweep; ready follows pat for the first pat_len cycles, then
    // random (rnd) or constant 1. noise scrambles start/bounds while running.
    task automatic run_sweep(input string name, input int lr, input int lc, input bit up,
                             input logic [31:0] pat, input int pat_len, input bit rnd,
                             input bit noise);
        logic [20:0] got, exp;
        bit rdy;
        int cyc;
        build_model(lr, lc, up);
        do_start(lr, lc, up);
        cyc = 0;
        while (exp_q.size() > 0) begin
            if (cyc > 2000) begin
                tests_run++;
                tests_failed++;
                $display("FAIL %s timeout got remaining=%0d required 0", name, exp_q.size());
                break;
            end
            got = {out_valid, row, col, row_end, sweep_end, busy, done};
            exp = {1'b1, exp_q[0].r, exp_q[0].c, exp_q[0].re, exp_q[0].se, 1'b1, 1'b0};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL %s pair%0d got v=%b r=%0d c=%0d re=%b se=%b b=%b d=%b required v=%b r=%0d c=%0d re=%b se=%b b=%b d=%b",
                         name, cyc, got[20], got[19:12], got[11:4], got[3], got[2], got[1], got[0],
                         exp[20], exp[19:12], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
            end
            if (cyc < pat_len) rdy = pat[cyc];
            else if (rnd)      rdy = 1'($urandom_range(0, 1));
            else               rdy = 1'b1;
            out_ready = rdy;
            if (noise) begin
                start    = 1'($urandom_range(0, 1));
                last_row = 8'($urandom_range(0, 7));
                last_col = 8'($urandom_range(0, 7));
                upper    = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            start = 1'b0;
            if (rdy) void'(exp_q.pop_front());
            cyc++;
        end
        out_ready = 1'b0;
        tests_run++;
        if ({out_valid, busy, done} !== 3'b001) begin
            tests_failed++;
            $display("FAIL %s done_pulse got v/b/d=%b required 001", name, {out_valid, busy, done});
        end
        @(negedge clk);
        tests_run++;
        if ({out_valid, busy, done, row_end, sweep_end} !== 5'b0) begin
            tests_failed++;
            $display("FAIL %s after_done got v/b/d/re/se=%b required 00000", name,
                     {out_valid, busy, done, row_end, sweep_end});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; upper = 1'b0;
        last_row = 8'd0; last_col = 8'd0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({out_valid, row, col, row_end, sweep_end, busy, done} !== 21'd0) begin
            tests_failed++;
            $display("FAIL reset got v=%b r=%0d c=%0d re=%b se=%b b=%b d=%b required all 0",
                     out_valid, row, col, row_end, sweep_end, busy, done);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rect();
        run_sweep("rect", 1, 2, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_upper();
        run_sweep("upper", 2, 2, 1'b1, 32'h0, 0, 1'b0, 1'b0);
        run_sweep("upper_clamp", 3, 1, 1'b1, 32'h0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_sweep("backpressure", 1, 1, 1'b0, 32'b1011001, 7, 1'b0, 1'b0);
    endtask

    task automatic test_single();
        run_sweep("single", 0, 0, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_sweep("start_in_run", 2, 3, 1'b0, 32'h0, 0, 1'b1, 1'b1);
    endtask

    task automatic test_abort();
        do_start(2, 2, 1'b0);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({out_valid, row, col} !== {1'b1, 8'd2, 8'd0}) begin
            tests_failed++;
            $display("FAIL abort_pre got v=%b r=%0d c=%0d required v=1 r=2 c=0", out_valid, row, col);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({out_valid, busy, done} !== 3'b000) begin
                tests_failed++;
                $display("FAIL abort_idle%0d got v/b/d=%b required 000", i, {out_valid, busy, done});
            end
            @(negedge clk);
        end
        start = 1'b1; abort = 1'b1; last_row = 8'd1; last_col = 8'd1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        tests_run++;
        if ({out_valid, busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL abort_over_start got v/b=%b required 00", {out_valid, busy});
        end
        run_sweep("after_abort", 2, 1, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_start(2, 2, 1'b0);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        tests_run++;
        if ({out_valid, row, col, row_end, sweep_end, busy, done} !== 21'd0) begin
            tests_failed++;
            $display("FAIL reset_mid got v=%b r=%0d c=%0d b=%b d=%b required all 0",
                     out_valid, row, col, busy, done);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_done got %b required 0", done);
        end
        run_sweep("after_reset", 2, 2, 1'b0, 32'h0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            run_sweep("random", $urandom_range(0, 5), $urandom_range(0, 5),
                      1'($urandom_range(0, 1)), 32'h0, 0, 1'b1, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_rect();
        test_upper();
        test_backpressure();
        test_single();
        test_start_ignored();
        test_abort();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running required finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/index_walker_down.md
Name: index_walker_down

Overview:
- Generates (row, col) index pairs in descending order, from (last_row, last_col) down to (0, 0). Output uses a valid/ready stream.
- Feeds back-substitution and other reverse-order matrix sweeps in the LCMV datapath. It is the descending counterpart of the ascending wrap-at-last counter used for forward sweeps.
- Supports full-rectangle traversal and upper-triangular traversal (col >= row).

Parameters:
WIDTH, 8, width of row/col indices and of the bound inputs

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  begin a sweep; sampled only in IDLE
abort  input  1  terminate the current sweep; no done pulse
upper  input  1  1 = upper-triangular traversal; latched at start
last_row  input  WIDTH  highest row index; latched at start
last_col  input  WIDTH  highest col index; latched at start
out_valid  output  1  row/col hold a valid index pair
out_ready  input  1  consumer accepts the pair when out_valid && out_ready
row  output  WIDTH  current row index
col  output  WIDTH  current col index
row_end  output  1  current pair is the last pair of its row
sweep_end  output  1  current pair is (0,0), the final pair
busy  output  1  a sweep is active (state RUN)
done  output  1  one-cycle pulse the cycle after the final pair is accepted

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high.
- Reset values: state=IDLE; out_valid=0, row=0, col=0, busy=0, done=0.
- row_end and sweep_end are combinational and qualified by out_valid; both are 0 in reset/IDLE.
- States: IDLE, RUN.
- Bound latching (IDLE, start=1, abort=0):
  - Latch upper and last_col.
  - Latched row bound = last_row, except when upper=1, where it is min(last_row, last_col).
  - Next cycle: state=RUN, out_valid=1, busy=1, row=row bound, col=last_col.
- Column floor: col_min = row when upper=1, else 0.
- row_end = out_valid && (col == col_min).
- sweep_end = row_end && (row == 0).
- Advance: occurs only on a handshake (out_valid && out_ready) in RUN.
  - If not row_end: col <= col - 1.
  - If row_end and not sweep_end: row <= row - 1, col <= latched last_col.
  - If sweep_end: next cycle state=IDLE, out_valid=0, busy=0, done=1 for exactly one cycle. row/col keep their last values.
- Backpressure: while out_valid=1 and out_ready=0, row, col, row_end and sweep_end are held stable. out_valid is never withdrawn without a handshake, except on abort or rst.
- Throughput: one pair per cycle while out_ready=1. No bubbles between rows.
- Sequence length: rectangular sweep emits (R+1)*(C+1) pairs; upper sweep emits sum over r=0..R of (C-r+1) pairs, where R and C are the latched row and col bounds.
- Single element (bounds 0,0): first pair has row_end=sweep_end=1. done follows its acceptance.
- start while RUN: ignored. Bound inputs are ignored outside the start cycle in IDLE.
- start and handshake of the final pair in the same cycle: start is ignored (state is RUN). A new sweep needs start in IDLE.
- abort:
  - In RUN: next cycle IDLE, out_valid=0, busy=0, done=0. abort wins over a same-cycle handshake, which is treated as accepted but not followed by done.
  - In IDLE: abort has priority over start; no sweep begins.
- rst mid-sweep: immediate return to reset values on the next edge. No done pulse.
- Arithmetic: decrements never underflow, because row/col decrement only when strictly above their floor. Width is fixed at WIDTH; no saturation logic is needed.

Test Plan:
- Rectangular sweep: last_row=1, last_col=2, upper=0, out_ready=1 -> pairs (1,2),(1,1),(1,0),(0,2),(0,1),(0,0) on 6 consecutive cycles. row_end on (1,0) and (0,0); sweep_end on (0,0); done pulse on the 7th cycle; busy high for cycles 1-6.
- Upper sweep: last_row=2, last_col=2, upper=1 -> (2,2),(1,2),(1,1),(0,2),(0,1),(0,0). row_end on (2,2),(1,1),(0,0). Clamped case last_row=3, last_col=1, upper=1 -> (1,1),(0,1),(0,0).
- Backpressure: rectangular 1x1 bounds with out_ready toggling 1,0,0,1,1,0,1 -> each pair is held stable while out_ready=0. Sequence (1,1),(1,0),(0,1),(0,0); done only after the final accept.
- Single element: bounds (0,0) -> one pair (0,0) with row_end=sweep_end=1, then done=1 for one cycle. out_valid=0 afterwards.
- Control hazards: start asserted during RUN with different bounds -> ignored, original sequence continues. abort after the 2nd pair -> out_valid=0 next cycle, done never asserts. A new start then begins again from (last_row, last_col).
- Reset mid-sweep: rst at pair 3 of a 3x3 sweep -> next cycle all outputs are at reset values, no done pulse. A subsequent start works normally.
